// File: rtl/rambus_arbiter.sv
// rambus_arbiter: round-robin owner of the shared OpenRAM wishbone port across NUM_REQ masters.
// Define RAMBUS_ARB_TIMEOUT_EN to add an stb-to-ack watchdog that errors and drops the stalled cycle.
module rambus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       m_cyc,
  input  logic [NUM_REQ-1:0]       m_stb,
  input  logic [NUM_REQ-1:0]       m_we,
  input  logic [4*NUM_REQ-1:0]     m_sel,
  input  logic [32*NUM_REQ-1:0]    m_dat,
  input  logic [ADDR_W*NUM_REQ-1:0] m_adr,
  output logic [NUM_REQ-1:0]       m_ack,
  output logic [NUM_REQ-1:0]       m_err,
  output logic [31:0]              m_dat_o,
  output logic                     rambus_wb_clk_o,
  output logic                     rambus_wb_rst_o,
  output logic                     rambus_wb_stb_o,
  output logic                     rambus_wb_cyc_o,
  output logic                     rambus_wb_we_o,
  output logic [3:0]               rambus_wb_sel_o,
  output logic [31:0]              rambus_wb_dat_o,
  output logic [ADDR_W-1:0]        rambus_wb_addr_o,
  input  logic                     rambus_wb_ack_i,
  input  logic [31:0]              rambus_wb_dat_i,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic {IDLE, OWN} state_t;
  state_t state;
  logic [IW-1:0] own, last, win;
  logic found, owning, kill;
  always_comb begin
    win = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!found && m_cyc[(int'(last) + k) % NUM_REQ]) begin
        found = 1'b1;
        win = IW'((int'(last) + k) % NUM_REQ);
      end
  end
  assign owning = state == OWN;
  assign rambus_wb_clk_o = clock;
  assign rambus_wb_rst_o = ~reset_n;
  assign rambus_wb_cyc_o = owning && !kill && m_cyc[own];
  assign rambus_wb_stb_o = owning && !kill && m_stb[own];
  assign rambus_wb_we_o = owning && m_we[own];
  assign rambus_wb_sel_o = owning ? m_sel[4*int'(own) +: 4] : '0;
  assign rambus_wb_dat_o = owning ? m_dat[32*int'(own) +: 32] : '0;
  assign rambus_wb_addr_o = owning ? m_adr[ADDR_W*int'(own) +: ADDR_W] : '0;
  assign m_ack = owning && rambus_wb_ack_i ? NUM_REQ'(1) << own : '0;
  assign m_dat_o = owning ? rambus_wb_dat_i : '0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      busy <= 1'b0;
      own <= '0;
      last <= IW'(NUM_REQ - 1);
    end else if (state == IDLE) begin
      if (found) begin
        state <= OWN;
        grant <= NUM_REQ'(1) << win;
        busy <= 1'b1;
        own <= win;
      end
    end else if (!m_cyc[own]) begin
      state <= IDLE;
      grant <= '0;
      busy <= 1'b0;
      last <= own;
    end
`ifdef RAMBUS_ARB_TIMEOUT_EN
  localparam int CWR = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = CWR < 8 ? 8 : (CWR > 16 ? 16 : CWR);
  logic [CW-1:0] cnt;
  logic stall, err_now;
  assign stall = rambus_wb_stb_o && !rambus_wb_ack_i;
  assign err_now = stall && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign m_err = err_now ? NUM_REQ'(1) << own : '0;
  // kill holds cyc/stb low until the owner gives up, which also freezes cnt
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      kill <= 1'b0;
    end else if (!owning) begin
      cnt <= '0;
      kill <= 1'b0;
    end else begin
      cnt <= rambus_wb_ack_i ? '0 : (stall ? cnt + 1'b1 : cnt);
      if (err_now) kill <= 1'b1;
    end
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign kill = 1'b0;
  assign m_err = '0;
`endif
endmodule

// File: tb/tb_rambus_arbiter.sv
// tb_rambus_arbiter: directed vector table plus hand sequences for round-robin, reset abort and watchdog.
module tb_rambus_arbiter;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [1:0] m_cyc = '0, m_stb = '0, m_we = 2'b01, m_ack, m_err, grant;
  logic [7:0] m_sel = {4'h3, 4'hF};
  logic [63:0] m_dat = {32'hCAFEF00D, 32'hDEADBEEF};
  logic [19:0] m_adr = {10'h3FF, 10'h010};
  logic [31:0] m_dat_o, rambus_wb_dat_o, rambus_wb_dat_i = 32'h12345678;
  logic rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_stb_o, rambus_wb_cyc_o, rambus_wb_we_o, busy;
  logic rambus_wb_ack_i = 1'b0;
  logic [3:0] rambus_wb_sel_o;
  logic [9:0] rambus_wb_addr_o;
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  rambus_arbiter #(.NUM_REQ(2), .ADDR_W(10), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset_n(reset_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_sel(m_sel), .m_dat(m_dat), .m_adr(m_adr), .m_ack(m_ack), .m_err(m_err),
    .m_dat_o(m_dat_o), .rambus_wb_clk_o(rambus_wb_clk_o), .rambus_wb_rst_o(rambus_wb_rst_o),
    .rambus_wb_stb_o(rambus_wb_stb_o), .rambus_wb_cyc_o(rambus_wb_cyc_o),
    .rambus_wb_we_o(rambus_wb_we_o), .rambus_wb_sel_o(rambus_wb_sel_o),
    .rambus_wb_dat_o(rambus_wb_dat_o), .rambus_wb_addr_o(rambus_wb_addr_o),
    .rambus_wb_ack_i(rambus_wb_ack_i), .rambus_wb_dat_i(rambus_wb_dat_i),
    .grant(grant), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [1:0] cyc, stb;
    logic ack;
    logic [1:0] grant;
    logic busy;
    logic [1:0] mack;
    logic rcyc;
    logic [9:0] addr;
    logic [31:0] dato;
  } vec_t;
  vec_t tv [24];
  logic [1:0] glog [$];
  logic [1:0] prevg;
  int rem [2], acks [2], drop [2], errs;
  initial begin
    tv = '{
      '{2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 10'h000, 32'h0},
      '{2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 1'b1, 10'h010, 32'h12345678},
      '{2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 10'h010, 32'h12345678},
      '{2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 10'h010, 32'h12345678},
      '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 10'h000, 32'h0},
      '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 10'h000, 32'h0},
      '{2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 10'h000, 32'h0},
      '{2'b11, 2'b11, 1'b0, 2'b10, 1'b1, 2'b00, 1'b1, 10'h3FF, 32'h12345678},
      '{2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 10'h3FF, 32'h12345678},
      '{2'b01, 2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 10'h3FF, 32'h12345678},
      '{2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 10'h000, 32'h0},
      '{2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 1'b1, 10'h010, 32'h12345678},
      '{2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 10'h010, 32'h12345678},
      '{2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 10'h010, 32'h12345678},
      '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 10'h000, 32'h0},
      '{2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 10'h000, 32'h0},
      '{2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 10'h010, 32'h12345678},
      '{2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 10'h010, 32'h12345678},
      '{2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 10'h010, 32'h12345678},
      '{2'b10, 2'b10, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 10'h010, 32'h12345678},
      '{2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 10'h000, 32'h0},
      '{2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 2'b00, 1'b1, 10'h3FF, 32'h12345678},
      '{2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 10'h3FF, 32'h12345678},
      '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 10'h000, 32'h0}
    };
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(m_ack), 0);
    chk("rst_err", 32'(m_err), 0);
    chk("rst_rst_o", 32'(rambus_wb_rst_o), 1);
    chk("rst_ctl", 32'({rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o, rambus_wb_sel_o}), 0);
    chk("rst_data", 32'(rambus_wb_addr_o) | rambus_wb_dat_o, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clock);
      #1;
      m_cyc = tv[i].cyc;
      m_stb = tv[i].stb;
      rambus_wb_ack_i = tv[i].ack;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tv[i].grant));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("v%0d_ack", i), 32'(m_ack), 32'(tv[i].mack));
      chk($sformatf("v%0d_err", i), 32'(m_err), 0);
      chk($sformatf("v%0d_cyc", i), 32'(rambus_wb_cyc_o), 32'(tv[i].rcyc));
      chk($sformatf("v%0d_stb", i), 32'(rambus_wb_stb_o), 32'(tv[i].rcyc));
      chk($sformatf("v%0d_addr", i), 32'(rambus_wb_addr_o), 32'(tv[i].addr));
      chk($sformatf("v%0d_dato", i), m_dat_o, tv[i].dato);
      if (tv[i].grant != 2'b00)
        chk($sformatf("v%0d_wdat", i), rambus_wb_dat_o, tv[i].grant[0] ? 32'hDEADBEEF : 32'hCAFEF00D);
    end
    rem = '{4, 4};
    acks = '{0, 0};
    drop = '{0, 0};
    prevg = 2'b00;
    for (int c = 0; c < 200 && (rem[0] > 0 || rem[1] > 0 || prevg != 2'b00); c++) begin
      @(posedge clock);
      #1;
      rambus_wb_ack_i = 1'b0;
      if (grant !== prevg) begin
        glog.push_back(grant);
        prevg = grant;
      end
      for (int i = 0; i < 2; i++) begin
        m_cyc[i] = rem[i] > 0 && drop[i] == 0;
        m_stb[i] = m_cyc[i];
        drop[i] = 0;
      end
      #1;
      rambus_wb_ack_i = rambus_wb_stb_o;
      #1;
      for (int i = 0; i < 2; i++)
        if (m_ack[i]) begin
          acks[i]++;
          rem[i]--;
          drop[i] = 1;
        end
    end
    rambus_wb_ack_i = 1'b0;
    chk("rr_acks0", acks[0], 4);
    chk("rr_acks1", acks[1], 4);
    chk("rr_len", glog.size(), 16);
    for (int j = 0; j < 16 && j < glog.size(); j++)
      chk($sformatf("rr_g%0d", j), 32'(glog[j]), j % 4 == 0 ? 1 : (j % 4 == 2 ? 2 : 0));
    @(posedge clock);
    #1;
    m_cyc = 2'b01;
    m_stb = 2'b01;
    @(posedge clock);
    #1;
    chk("ab_grant_pre", 32'(grant), 1);
    rambus_wb_ack_i = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("ab_grant", 32'(grant), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_cyc", 32'(rambus_wb_cyc_o), 0);
    chk("ab_rst_o", 32'(rambus_wb_rst_o), 1);
    chk("ab_ack", 32'(m_ack), 0);
    @(posedge clock);
    #1;
    rambus_wb_ack_i = 1'b0;
    reset_n = 1'b1;
    errs = 0;
`ifdef RAMBUS_ARB_TIMEOUT_EN
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      #2;
      chk($sformatf("to_err%0d", k), 32'(m_err), k == 8 ? 1 : 0);
      chk($sformatf("to_stb%0d", k), 32'(rambus_wb_stb_o), k <= 8 ? 1 : 0);
    end
    m_cyc = 2'b00;
    m_stb = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    chk("to_release", 32'(grant), 0);
`else
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clock);
      #2;
      if (m_err != 2'b00) errs++;
    end
    chk("noto_err", errs, 0);
    chk("noto_stb", 32'(rambus_wb_stb_o), 1);
    chk("noto_grant", 32'(grant), 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
